// File: rtl/palu_pkg.sv
// Shared types and constants for the palu multi-cycle ALU: op codes, FSM states
// and NZCV flag bit positions.
package palu_pkg;

    typedef enum logic [4:0] {
        OP_CPY = 5'd0,
        OP_ADD = 5'd1,
        OP_ADC = 5'd2,
        OP_SUB = 5'd3,
        OP_SBC = 5'd4,
        OP_CMP = 5'd5,
        OP_NEG = 5'd6,
        OP_AND = 5'd7,
        OP_OR  = 5'd8,
        OP_BIC = 5'd9,
        OP_XOR = 5'd10,
        OP_NOT = 5'd11,
        OP_LSL = 5'd12,
        OP_LSR = 5'd13,
        OP_ASR = 5'd14,
        OP_MUL = 5'd15
    } palu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } palu_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift(input palu_op_t op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/palu_core.sv
// Combinational result and NZCV for the single-cycle codes (CPY..NOT).
// C and V come from the shared adder for arithmetic ops, otherwise pass through.
module palu_core
    import palu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  palu_op_t         i_op,
    input  logic [3:0]       i_flags,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;

    // Every arithmetic op is x + y + cin; subtraction feeds ~b so carry-out means "no borrow".
    always_comb begin
        w_x     = i_a;
        w_y     = i_b;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (i_op)
            OP_ADD: w_arith = 1'b1;
            OP_ADC: begin
                w_arith = 1'b1;
                w_cin   = i_flags[FLAG_C];
            end
            OP_SUB, OP_CMP: begin
                w_arith = 1'b1;
                w_y     = ~i_b;
                w_cin   = 1'b1;
            end
            OP_SBC: begin
                w_arith = 1'b1;
                w_y     = ~i_b;
                w_cin   = i_flags[FLAG_C];
            end
            OP_NEG: begin
                w_arith = 1'b1;
                w_x     = '0;
                w_y     = ~i_b;
                w_cin   = 1'b1;
            end
            default: ;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    end

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_CPY: o_result = i_a;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP, OP_NEG: o_result = w_sum[WIDTH-1:0];
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_BIC: o_result = i_a & ~i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOT: o_result = ~i_a;
            default: o_result = '0;
        endcase

        o_flags         = i_flags;
        o_flags[FLAG_N] = o_result[WIDTH-1];
        o_flags[FLAG_Z] = (o_result == '0);
        if (w_arith) begin
            o_flags[FLAG_C] = w_sum[WIDTH];
            o_flags[FLAG_V] = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
        end
    end

endmodule

// File: rtl/palu.sv
// palu top: start/done FSM, single-cycle commit via palu_core, one-bit-per-clock
// shifts and (when PALU_MUL_EN is defined) a shift-add multiplier.
module palu
    import palu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       op,
    input  logic             fue,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       fout,
    output logic             busy,
    output logic             done
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    palu_state_t      r_state;
    palu_state_t      w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    palu_op_t         r_op;
    logic             r_fue;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_fout;
    logic             r_done;
`ifdef PALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
`endif

    palu_op_t         w_op_in;
    logic [SW-1:0]    w_k;
    logic             w_mul_in;
    logic [WIDTH-1:0] w_core_result;
    logic [3:0]       w_core_flags;

    logic             w_commit;
    logic [WIDTH-1:0] w_commit_out;
    logic [3:0]       w_commit_flags;
    logic             w_write_flags;
    logic             w_launch;
    logic [CW-1:0]    w_launch_cnt;
    logic [WIDTH-1:0] w_launch_acc;
    logic             w_step;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_shift_c;

    assign w_op_in = palu_op_t'(op);
    assign w_k     = in2[SW-1:0];
`ifdef PALU_MUL_EN
    assign w_mul_in = (w_op_in == OP_MUL);
`else
    assign w_mul_in = 1'b0;
`endif

    palu_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (in1),
        .i_b      (in2),
        .i_op     (w_op_in),
        .i_flags  (r_fout),
        .o_result (w_core_result),
        .o_flags  (w_core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_commit       = 1'b0;
        w_commit_out   = '0;
        w_commit_flags = r_fout;
        w_write_flags  = 1'b0;
        w_launch       = 1'b0;
        w_launch_cnt   = '0;
        w_launch_acc   = in1;
        w_step         = 1'b0;
        w_acc_next     = r_acc;
        w_shift_c      = r_fout[FLAG_C];

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift(w_op_in) && (w_k != '0)) begin
                        w_launch     = 1'b1;
                        w_launch_cnt = CW'(w_k);
                        w_state_next = ST_RUN;
                    end else if (w_mul_in) begin
                        w_launch     = 1'b1;
                        w_launch_cnt = CW'(WIDTH);
                        w_launch_acc = '0;
                        w_state_next = ST_RUN;
                    end else begin
                        w_commit      = 1'b1;
                        w_write_flags = fue;
                        if (is_shift(w_op_in)) begin
                            // Zero-distance shift: pass in1 through, C and V untouched.
                            w_commit_out           = in1;
                            w_commit_flags[FLAG_N] = in1[WIDTH-1];
                            w_commit_flags[FLAG_Z] = (in1 == '0);
                        end else if (op <= 5'd11) begin
                            w_commit_out   = w_core_result;
                            w_commit_flags = w_core_flags;
                        end else begin
                            w_commit_out  = '0;
                            w_write_flags = 1'b0;
                        end
                    end
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                case (r_op)
                    OP_LSL: begin
                        w_acc_next = {r_acc[WIDTH-2:0], 1'b0};
                        w_shift_c  = r_acc[WIDTH-1];
                    end
                    OP_LSR: begin
                        w_acc_next = {1'b0, r_acc[WIDTH-1:1]};
                        w_shift_c  = r_acc[0];
                    end
                    OP_ASR: begin
                        w_acc_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
                        w_shift_c  = r_acc[0];
                    end
                    default: begin
`ifdef PALU_MUL_EN
                        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif
                    end
                endcase
                if (r_cnt == CW'(1)) begin
                    w_commit               = 1'b1;
                    w_commit_out           = w_acc_next;
                    w_commit_flags[FLAG_N] = w_acc_next[WIDTH-1];
                    w_commit_flags[FLAG_Z] = (w_acc_next == '0);
                    w_commit_flags[FLAG_C] = w_shift_c;
                    w_write_flags          = r_fue;
                    w_state_next           = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_op     <= OP_CPY;
            r_fue    <= 1'b0;
            r_out    <= '0;
            r_fout   <= '0;
            r_done   <= 1'b0;
`ifdef PALU_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
`endif
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_out <= w_commit_out;
                if (w_write_flags) begin
                    r_fout <= w_commit_flags;
                end
            end
            if (w_launch) begin
                r_acc    <= w_launch_acc;
                r_cnt    <= w_launch_cnt;
                r_op     <= w_op_in;
                r_fue    <= fue;
`ifdef PALU_MUL_EN
                r_mcand  <= in1;
                r_mplier <= in2;
`endif
            end else if (w_step) begin
                r_acc    <= w_acc_next;
                r_cnt    <= r_cnt - CW'(1);
`ifdef PALU_MUL_EN
                r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
`endif
            end
        end
    end

    assign out  = r_out;
    assign fout = r_fout;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;

endmodule
